// File: rtl/tdm_demux4_pkg.sv
// Shared TDM link definitions: frame geometry, receiver FSM encoding and slot decode.
package tdm_demux4_pkg;

    localparam int TDM_SLOTS  = 4;
    localparam int TDM_SLOT_W = 2;
    localparam int TDM_WORD_W = 8;

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } tdm_state_e;

    function automatic logic [TDM_SLOTS-1:0] slot_onehot(input logic [TDM_SLOT_W-1:0] slot);
        logic [TDM_SLOTS-1:0] oh;
        case (slot)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/tdm_demux4_sipo_shift.sv
// Serial-in parallel-out word assembler. Holds the first WORD_W-1 bits of a word;
// word presents them joined with the bit currently on din so a word closes with no extra cycle.
module sipo_shift #(
    parameter int WORD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              din,
    output logic [WORD_W-1:0] word
);

    logic [WORD_W-2:0] sr_r;
    logic [WORD_W-2:0] sr_nxt_s;

    assign word = {sr_r, din};

    // Next contents: clr restarts the word with din as its first bit.
    always_comb begin
        sr_nxt_s = sr_r;
        if (en) begin
            if (clr) begin
                sr_nxt_s    = '0;
                sr_nxt_s[0] = din;
            end else begin
                sr_nxt_s = word[WORD_W-2:0];
            end
        end else begin
            sr_nxt_s = sr_r;
        end
    end

    // Shift register storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r <= '0;
        end else begin
            sr_r <= sr_nxt_s;
        end
    end

endmodule

// File: rtl/tdm_demux4.sv
// Receive end of the 4-channel TDM link: locks to frame sync, counts bits/slots and
// de-interleaves the serial stream into four channel registers with valid strobes.
module tdm_demux4
    import tdm_demux4_pkg::*;
#(
    parameter int WORD_W = TDM_WORD_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic                          din,
    input  logic                          sync,
    output logic [TDM_SLOTS*WORD_W-1:0]   ch_data,
    output logic [TDM_SLOTS-1:0]          ch_valid,
    output logic                          frame_done,
    output logic                          locked,
    output logic                          frame_err
);

    localparam int CNT_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 1);

    tdm_state_e                     state_r, state_nxt_s;
    logic [CNT_W-1:0]               bit_cnt_r, bit_cnt_nxt_s;
    logic [TDM_SLOT_W-1:0]          slot_r, slot_nxt_s;
    logic                           sh_en_s, sh_clr_s;
    logic [WORD_W-1:0]              word_s;
    logic                           wr_s, err_s;
    logic [TDM_SLOTS*WORD_W-1:0]    ch_data_r, ch_data_nxt_s;
    logic [TDM_SLOTS-1:0]           ch_valid_r, ch_valid_nxt_s;
    logic                           frame_done_r, frame_err_r;

    sipo_shift #(.WORD_W(WORD_W)) u_sipo (
        .clk  (clk),
        .rst  (rst),
        .en   (sh_en_s),
        .clr  (sh_clr_s),
        .din  (din),
        .word (word_s)
    );

    // FSM next state, counters and sync check. A misplaced sync always wins over word completion.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        slot_nxt_s    = slot_r;
        sh_en_s       = 1'b0;
        sh_clr_s      = 1'b0;
        wr_s          = 1'b0;
        err_s         = 1'b0;
        if (en) begin
            case (state_r)
                ST_HUNT: begin
                    if (sync) begin
                        state_nxt_s   = ST_LOCKED;
                        bit_cnt_nxt_s = CNT_W'(1);
                        slot_nxt_s    = 2'd0;
                        sh_en_s       = 1'b1;
                        sh_clr_s      = 1'b1;
                    end else begin
                        state_nxt_s = ST_HUNT;
                    end
                end
                ST_LOCKED: begin
                    if ((bit_cnt_r == '0) && (slot_r == 2'd0) && !sync) begin
                        state_nxt_s   = ST_HUNT;
                        bit_cnt_nxt_s = '0;
                        slot_nxt_s    = 2'd0;
                        err_s         = 1'b1;
                    end else if (((bit_cnt_r != '0) || (slot_r != 2'd0)) && sync) begin
                        bit_cnt_nxt_s = CNT_W'(1);
                        slot_nxt_s    = 2'd0;
                        sh_en_s       = 1'b1;
                        sh_clr_s      = 1'b1;
                        err_s         = 1'b1;
                    end else begin
                        sh_en_s = 1'b1;
                        if (bit_cnt_r == LAST_BIT) begin
                            bit_cnt_nxt_s = '0;
                            slot_nxt_s    = slot_r + 2'd1;
                            wr_s          = 1'b1;
                        end else begin
                            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt_s   = ST_HUNT;
                    bit_cnt_nxt_s = '0;
                    slot_nxt_s    = 2'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Channel write target decode and valid strobe generation.
    always_comb begin
        ch_data_nxt_s  = ch_data_r;
        ch_valid_nxt_s = '0;
        if (wr_s) begin
            ch_valid_nxt_s = slot_onehot(slot_r);
            case (slot_r)
                2'd0:    ch_data_nxt_s[0*WORD_W +: WORD_W] = word_s;
                2'd1:    ch_data_nxt_s[1*WORD_W +: WORD_W] = word_s;
                2'd2:    ch_data_nxt_s[2*WORD_W +: WORD_W] = word_s;
                2'd3:    ch_data_nxt_s[3*WORD_W +: WORD_W] = word_s;
                default: ch_data_nxt_s = ch_data_r;
            endcase
        end else begin
            ch_valid_nxt_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counters, channel registers and registered strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r    <= '0;
            slot_r       <= 2'd0;
            ch_data_r    <= '0;
            ch_valid_r   <= '0;
            frame_done_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            bit_cnt_r    <= bit_cnt_nxt_s;
            slot_r       <= slot_nxt_s;
            ch_data_r    <= ch_data_nxt_s;
            ch_valid_r   <= ch_valid_nxt_s;
            frame_done_r <= ch_valid_nxt_s[TDM_SLOTS-1];
            frame_err_r  <= err_s;
        end
    end

    assign ch_data    = ch_data_r;
    assign ch_valid   = ch_valid_r;
    assign frame_done = frame_done_r;
    assign frame_err  = frame_err_r;
    assign locked     = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: 8-bit build for lock/realign/reset cases, 4-bit build for width scaling.
module tb_tdm_demux4;

    logic        clk = 1'b0;
    logic        rst, en, din, sync;
    logic [31:0] ch_data;
    logic [3:0]  ch_valid;
    logic        frame_done, locked, frame_err;

    logic        rst4, en4, din4, sync4;
    logic [15:0] ch_data4;
    logic [3:0]  ch_valid4;
    logic        frame_done4, locked4, frame_err4;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tdm_demux4 #(.WORD_W(8)) dut8 (
        .clk(clk), .rst(rst), .en(en), .din(din), .sync(sync),
        .ch_data(ch_data), .ch_valid(ch_valid), .frame_done(frame_done),
        .locked(locked), .frame_err(frame_err)
    );

    tdm_demux4 #(.WORD_W(4)) dut4 (
        .clk(clk), .rst(rst4), .en(en4), .din(din4), .sync(sync4),
        .ch_data(ch_data4), .ch_valid(ch_valid4), .frame_done(frame_done4),
        .locked(locked4), .frame_err(frame_err4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One en cycle on the 8-bit build, then check strobes and lock after the sampling edge.
    task automatic drv8(input logic d, input logic s, input logic [3:0] ev,
                        input logic ee, input logic el, input string tag);
        en = 1'b1; din = d; sync = s;
        @(posedge clk); #1;
        en = 1'b0; din = 1'b0; sync = 1'b0;
        chk({tag, ".valid"}, {60'd0, ch_valid}, {60'd0, ev});
        chk({tag, ".done"},  {63'd0, frame_done}, {63'd0, ev[3]});
        chk({tag, ".err"},   {63'd0, frame_err}, {63'd0, ee});
        chk({tag, ".lock"},  {63'd0, locked}, {63'd0, el});
    endtask

    task automatic idle8(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            chk({tag, ".idle_valid"}, {60'd0, ch_valid}, 64'd0);
            chk({tag, ".idle_done"},  {63'd0, frame_done}, 64'd0);
            chk({tag, ".idle_err"},   {63'd0, frame_err}, 64'd0);
        end
    endtask

    task automatic send8(input logic [7:0] w, input logic s, input int gap, input logic [3:0] ev,
                         input logic ee_first, input logic el, input string tag);
        for (int i = 7; i >= 0; i--) begin
            if (gap > 0) idle8(gap, tag);
            drv8(w[i], s && (i == 7), (i == 0) ? ev : 4'b0000,
                 (i == 7) ? ee_first : 1'b0, el, tag);
        end
    endtask

    task automatic drv4(input logic d, input logic s, input logic [3:0] ev, input string tag);
        en4 = 1'b1; din4 = d; sync4 = s;
        @(posedge clk); #1;
        en4 = 1'b0; din4 = 1'b0; sync4 = 1'b0;
        chk({tag, ".valid"}, {60'd0, ch_valid4}, {60'd0, ev});
        chk({tag, ".done"},  {63'd0, frame_done4}, {63'd0, ev[3]});
        chk({tag, ".err"},   {63'd0, frame_err4}, 64'd0);
        chk({tag, ".lock"},  {63'd0, locked4}, 64'd1);
    endtask

    initial begin
        logic [7:0] de_w, c3_w, v55_w, e7_w;
        logic [3:0] w4;
        de_w = 8'hDE; c3_w = 8'hC3; v55_w = 8'h55; e7_w = 8'hE7;

        rst = 1'b1; en = 1'b0; din = 1'b0; sync = 1'b0;
        rst4 = 1'b1; en4 = 1'b0; din4 = 1'b0; sync4 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.data",  {32'd0, ch_data}, 64'd0);
        chk("rst.valid", {60'd0, ch_valid}, 64'd0);
        chk("rst.done",  {63'd0, frame_done}, 64'd0);
        chk("rst.lock",  {63'd0, locked}, 64'd0);
        chk("rst.err",   {63'd0, frame_err}, 64'd0);
        chk("rst4.data", {48'd0, ch_data4}, 64'd0);
        chk("rst4.lock", {63'd0, locked4}, 64'd0);
        rst = 1'b0; rst4 = 1'b0;

        // Test 1: continuous en, one clean frame.
        send8(8'hA5, 1'b1, 0, 4'b0001, 1'b0, 1'b1, "t1.w0");
        chk("t1.ch0", {32'd0, ch_data}, 64'h0000_00A5);
        send8(8'h3C, 1'b0, 0, 4'b0010, 1'b0, 1'b1, "t1.w1");
        send8(8'h0F, 1'b0, 0, 4'b0100, 1'b0, 1'b1, "t1.w2");
        send8(8'hF0, 1'b0, 0, 4'b1000, 1'b0, 1'b1, "t1.w3");
        chk("t1.data", {32'd0, ch_data}, 64'hF00F_3CA5);
        idle8(1, "t1.after");

        // Test 2: reset, then the same frame with en every third clock.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t2.rst_data", {32'd0, ch_data}, 64'd0);
        chk("t2.rst_lock", {63'd0, locked}, 64'd0);
        send8(8'hA5, 1'b1, 2, 4'b0001, 1'b0, 1'b1, "t2.w0");
        send8(8'h3C, 1'b0, 2, 4'b0010, 1'b0, 1'b1, "t2.w1");
        send8(8'h0F, 1'b0, 2, 4'b0100, 1'b0, 1'b1, "t2.w2");
        send8(8'hF0, 1'b0, 2, 4'b1000, 1'b0, 1'b1, "t2.w3");
        idle8(2, "t2.after");
        chk("t2.data", {32'd0, ch_data}, 64'hF00F_3CA5);

        // Test 3: missing sync at frame start drops lock; next good frame relocks.
        send8(8'h11, 1'b0, 0, 4'b0000, 1'b1, 1'b0, "t3.bad");
        chk("t3.data_hold", {32'd0, ch_data}, 64'hF00F_3CA5);
        send8(8'h12, 1'b1, 0, 4'b0001, 1'b0, 1'b1, "t3.w0");
        send8(8'h34, 1'b0, 0, 4'b0010, 1'b0, 1'b1, "t3.w1");
        send8(8'h56, 1'b0, 0, 4'b0100, 1'b0, 1'b1, "t3.w2");
        send8(8'h78, 1'b0, 0, 4'b1000, 1'b0, 1'b1, "t3.w3");
        chk("t3.data", {32'd0, ch_data}, 64'h7856_3412);

        // Test 4: sync at slot 2 bit 5 realigns; following bits form a ch0 word.
        send8(8'h9A, 1'b1, 0, 4'b0001, 1'b0, 1'b1, "t4.w0");
        send8(8'hBC, 1'b0, 0, 4'b0010, 1'b0, 1'b1, "t4.w1");
        for (int i = 7; i >= 3; i--) drv8(de_w[i], 1'b0, 4'b0000, 1'b0, 1'b1, "t4.pre");
        drv8(c3_w[7], 1'b1, 4'b0000, 1'b1, 1'b1, "t4.sync");
        for (int i = 6; i >= 0; i--)
            drv8(c3_w[i], 1'b0, (i == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b1, "t4.post");
        chk("t4.data", {32'd0, ch_data}, 64'h7856_BCC3);

        // Sync on the last bit of slot 1: no ch1 write, realign into ch0.
        for (int i = 7; i >= 1; i--) drv8(v55_w[i], 1'b0, 4'b0000, 1'b0, 1'b1, "t4b.pre");
        drv8(e7_w[7], 1'b1, 4'b0000, 1'b1, 1'b1, "t4b.sync");
        for (int i = 6; i >= 0; i--)
            drv8(e7_w[i], 1'b0, (i == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b1, "t4b.post");
        chk("t4b.data", {32'd0, ch_data}, 64'h7856_BCE7);

        // Test 5: reset mid slot 1 (with en and sync high), then a sync-less stream.
        for (int i = 0; i < 3; i++) drv8(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, "t5.pre");
        rst = 1'b1; en = 1'b1; din = 1'b1; sync = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; en = 1'b0; din = 1'b0; sync = 1'b0;
        chk("t5.data",  {32'd0, ch_data}, 64'd0);
        chk("t5.valid", {60'd0, ch_valid}, 64'd0);
        chk("t5.done",  {63'd0, frame_done}, 64'd0);
        chk("t5.lock",  {63'd0, locked}, 64'd0);
        chk("t5.err",   {63'd0, frame_err}, 64'd0);
        for (int i = 0; i < 16; i++)
            drv8(1'($urandom_range(1, 0)), 1'b0, 4'b0000, 1'b0, 1'b0, "t5.nosync");
        chk("t5.data_after", {32'd0, ch_data}, 64'd0);

        // Test 6: 4-bit build, words 1,2,3,4.
        for (int k = 0; k < 4; k++) begin
            w4 = 4'(k + 1);
            for (int i = 3; i >= 0; i--)
                drv4(w4[i], (k == 0) && (i == 3),
                     (i == 0) ? (4'b0001 << k) : 4'b0000, "t6");
        end
        chk("t6.data", {48'd0, ch_data4}, 64'h4321);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
